// File: rtl/add_arb_sched_pkg.sv
// add_arb_sched_pkg: shared types and constants for the shared-adder arbiter
package add_arb_sched_pkg;
    localparam int NREQ      = 2;
    localparam int WIDTH_DEF = 36;
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
endpackage

// File: rtl/add_arb_sched_arb2_rr.sv
// arb2_rr: 2-way round-robin / fixed-priority grant generator with lock override
module arb2_rr #(
    parameter int PRIO_FIXED = 0
) (
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       rr,
    input  logic       lock,
    input  logic       lock_id,
    output logic [1:0] gnt
);
    logic w_tie;
    assign w_tie = (PRIO_FIXED != 0) ? 1'b0 : rr;
    // a held lock admits only its owner; otherwise a tie goes to w_tie
    assign gnt = reset ? 2'b00 :
                 lock  ? (req & (lock_id ? 2'b10 : 2'b01)) :
                 (&req) ? (w_tie ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/add_arb_sched.sv
// add_arb_sched: arbitrates two requesters onto one shared adder, chaining double-word beats
module add_arb_sched
    import add_arb_sched_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PRIO_FIXED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       dbl,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ-1:0]       op_cin,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_hi
);
    arb_state_t r_state, w_state_n;
    logic r_rr, w_rr_n, r_cy, w_cy_n;
    logic w_lock, w_xfer, w_sel;

    assign w_lock = r_state != IDLE;
    assign w_xfer = |(req & gnt);
    assign w_sel  = w_xfer ? gnt[1] : r_rr;

    arb2_rr #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
        .reset   (reset),
        .req     (req),
        .rr      (r_rr),
        .lock    (w_lock),
        .lock_id (r_state == LOCK1),
        .gnt     (gnt)
    );

    assign add_a   = w_sel ? op_a[2*WIDTH-1:WIDTH] : op_a[WIDTH-1:0];
    assign add_b   = w_sel ? op_b[2*WIDTH-1:WIDTH] : op_b[WIDTH-1:0];
    assign add_cin = w_lock ? r_cy : op_cin[w_sel];

    // state, rr pointer and carry latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rr    <= 1'b0;
            r_cy    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_rr    <= w_rr_n;
            r_cy    <= w_cy_n;
        end
    end

    // low beat of a double-word add takes the lock; any other transfer releases it
    always_comb begin
        w_state_n = r_state;
        w_rr_n    = r_rr;
        w_cy_n    = r_cy;
        if (w_xfer && !w_lock && dbl[w_sel]) begin
            w_state_n = w_sel ? LOCK1 : LOCK0;
            w_cy_n    = add_cout;
        end else if (w_xfer) begin
            w_state_n = IDLE;
            w_rr_n    = ~w_sel;
            w_cy_n    = 1'b0;
        end
    end

    // one-cycle response strobe; result fields hold between transfers
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_hi    <= 1'b0;
        end else begin
            rsp_valid <= req & gnt;
            if (w_xfer) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
                rsp_hi   <= w_lock;
            end
        end
    end
endmodule

// File: tb/tb_add_arb_sched.sv
// tb_add_arb_sched: directed self-checking bench for the shared-adder arbiter
module tb_add_arb_sched;
    localparam int W = 36;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] req = '0, dbl = '0, cin = '0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] gnt, gnt_f, rsp_valid, rsp_valid_f;
    logic [W-1:0] add_a, add_b, add_sum, rsp_sum;
    logic [W-1:0] add_a_f, add_b_f, add_sum_f, rsp_sum_f;
    logic add_cin, add_cout, rsp_cout, rsp_hi;
    logic add_cin_f, add_cout_f, rsp_cout_f, rsp_hi_f;
    int n_chk = 0, n_fail = 0;
    localparam logic [W-1:0] ONES = 36'o777777777777;

    always #5 clk = ~clk;

    assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign {add_cout_f, add_sum_f} = {1'b0, add_a_f} + {1'b0, add_b_f} + {{W{1'b0}}, add_cin_f};

    add_arb_sched #(.WIDTH(W), .PRIO_FIXED(0)) dut (
        .clk(clk), .reset(reset), .req(req), .dbl(dbl),
        .op_a({a1, a0}), .op_b({b1, b0}), .op_cin(cin),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_hi(rsp_hi)
    );

    add_arb_sched #(.WIDTH(W), .PRIO_FIXED(1)) dut_f (
        .clk(clk), .reset(reset), .req(req), .dbl(dbl),
        .op_a({a1, a0}), .op_b({b1, b0}), .op_cin(cin),
        .gnt(gnt_f), .add_a(add_a_f), .add_b(add_b_f), .add_cin(add_cin_f),
        .add_sum(add_sum_f), .add_cout(add_cout_f),
        .rsp_valid(rsp_valid_f), .rsp_sum(rsp_sum_f), .rsp_cout(rsp_cout_f), .rsp_hi(rsp_hi_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        req = 2'b11;
        #1 chk("gnt_in_reset", gnt, 2'b00);
        tick();
        tick();
        reset = 1'b0;
        req   = 2'b00;
        chk("rst_valid", rsp_valid, 2'b00);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_hi", rsp_hi, 0);

        // single add from requester 0
        req = 2'b01; a0 = 36'o1; b0 = 36'o2; cin = 2'b00;
        #1 chk("single_gnt", gnt, 2'b01);
        chk("single_add_a", add_a, 36'o1);
        tick();
        req = 2'b00;
        chk("single_valid", rsp_valid, 2'b01);
        chk("single_sum", rsp_sum, 36'o3);
        chk("single_cout", rsp_cout, 0);
        chk("single_hi", rsp_hi, 0);
        tick();
        chk("idle_valid_clear", rsp_valid, 2'b00);
        chk("idle_sum_hold", rsp_sum, 36'o3);

        // contention after reset: 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 2'b11; a0 = 'h10; b0 = 'h1; a1 = 'h20; b1 = 'h2;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("rr_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_sum", rsp_sum, (k % 2 == 0) ? 'h11 : 'h22);
        end

        // make rr point at requester 1, then double-word add from 1 with req0 held
        req = 2'b01;
        #1 chk("pre_gnt", gnt, 2'b01);
        tick();
        req = 2'b11; dbl = 2'b10; a1 = ONES; b1 = 36'o1; cin = 2'b00;
        #1 chk("dw_lo_gnt", gnt, 2'b10);
        chk("dw_lo_cin", add_cin, 0);
        tick();
        chk("dw_lo_valid", rsp_valid, 2'b10);
        chk("dw_lo_sum", rsp_sum, 0);
        chk("dw_lo_cout", rsp_cout, 1);
        chk("dw_lo_hi", rsp_hi, 0);
        a1 = '0; b1 = '0;
        #1 chk("dw_hi_gnt", gnt, 2'b10);
        chk("dw_hi_cin", add_cin, 1);
        tick();
        chk("dw_hi_valid", rsp_valid, 2'b10);
        chk("dw_hi_sum", rsp_sum, 36'o1);
        chk("dw_hi_cout", rsp_cout, 0);
        chk("dw_hi_hi", rsp_hi, 1);
        dbl = 2'b00;
        #1 chk("dw_after_gnt", gnt, 2'b01);
        tick();
        chk("dw_after_valid", rsp_valid, 2'b01);

        // lock stall: requester 1 drops between beats
        req = 2'b10; dbl = 2'b10; a1 = ONES; b1 = 36'o1;
        #1 chk("stall_lo_gnt", gnt, 2'b10);
        tick();
        req = 2'b01; dbl = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_gnt", gnt, 2'b00);
            tick();
            chk("stall_valid", rsp_valid, 2'b00);
        end
        req = 2'b11; a1 = 'h5; b1 = '0;
        #1 chk("stall_hi_gnt", gnt, 2'b10);
        chk("stall_hi_cin", add_cin, 1);
        tick();
        chk("stall_hi_sum", rsp_sum, 'h6);
        chk("stall_hi_hi", rsp_hi, 1);

        // reset while in LOCK0
        req = 2'b01; dbl = 2'b01; a0 = ONES; b0 = 36'o1; cin = 2'b00;
        #1 chk("l0_lo_gnt", gnt, 2'b01);
        tick();
        chk("l0_lo_cout", rsp_cout, 1);
        reset = 1'b1;
        #1 chk("l0_rst_gnt", gnt, 2'b00);
        tick();
        reset = 1'b0;
        req = 2'b10; dbl = 2'b00; a1 = 36'o1; b1 = 36'o1;
        chk("l0_rst_valid", rsp_valid, 2'b00);
        #1 chk("post_rst_gnt", gnt, 2'b10);
        chk("post_rst_cin", add_cin, 0);
        tick();
        chk("post_rst_valid", rsp_valid, 2'b10);
        chk("post_rst_sum", rsp_sum, 36'o2);

        // fixed priority versus round-robin under sustained contention
        req = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 2'b11; a0 = 'h1; b0 = 'h1; a1 = 'h2; b1 = 'h2;
        for (int k = 0; k < 3; k++) begin
            #1 chk("fixed_gnt", gnt_f, 2'b01);
            chk("rr2_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("fixed_valid", rsp_valid_f, 2'b01);
        end
        req = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/add_arb_sched.md
Name: add_arb_sched

Overview:
- Shares one combinational carry-lookahead adder (36-bit, built from lookahead-generator slices) between two requesters, e.g. EBOX arithmetic and address-calculation logic.
- Arbitrates requests, multiplexes operands and carry-in onto the adder, and registers results back to the winner.
- Sequences double-word (72-bit) adds as two locked back-to-back beats, chaining the low-word carry-out into the high-word carry-in.

Parameters:
- WIDTH, 36, adder word width in bits.
- PRIO_FIXED, 0, 0 = round-robin arbitration; 1 = requester 0 always wins ties.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; held high until granted.
- dbl  in  2  per-requester flag: this request is a double-word add, presented low beat first.
- op_a  in  2xWIDTH  per-requester operand A.
- op_b  in  2xWIDTH  per-requester operand B.
- op_cin  in  2  per-requester carry-in, used on single and low beats only.
- gnt  out  2  combinational grant; a transfer occurs when req[i] & gnt[i].
- add_a  out  WIDTH  operand A driven to the shared adder.
- add_b  out  WIDTH  operand B driven to the shared adder.
- add_cin  out  1  carry-in driven to the shared adder.
- add_sum  in  WIDTH  sum from the shared adder, valid in the same cycle.
- add_cout  in  1  carry-out from the shared adder, valid in the same cycle.
- rsp_valid  out  2  per-requester one-cycle result strobe.
- rsp_sum  out  WIDTH  registered sum, shared by both requesters.
- rsp_cout  out  1  registered carry-out.
- rsp_hi  out  1  result is the high beat of a double-word add.

Behaviour:
- Reset values:
  - state IDLE; rr pointer 0; carry latch 0.
  - rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_hi 0.
  - gnt 0 while reset is high.
- States:
  - IDLE: no lock held.
  - LOCK0 / LOCK1: between the beats of a double-word add owned by requester 0 / 1.
- IDLE grant rules:
  - Only one requester asserting: grant it.
  - Both asserting, PRIO_FIXED=0: grant rr.
  - Both asserting, PRIO_FIXED=1: grant requester 0.
  - gnt is one-hot or zero.
- Transfer in IDLE:
  - add_a/add_b = op_a/op_b of the winner; add_cin = op_cin of the winner.
  - Next cycle: rsp_valid[i]=1, rsp_sum/rsp_cout = captured add_sum/add_cout, rsp_hi=0.
  - If dbl[i]=1: latch add_cout into the carry latch and go to LOCKi; rr unchanged.
  - If dbl[i]=0: stay IDLE and set rr to the other requester.
- LOCKi:
  - gnt[i]=req[i]; the other requester is never granted.
  - On transfer: add_cin = carry latch (op_cin ignored; dbl ignored).
  - Next cycle: rsp_valid[i]=1, rsp_hi=1.
  - Go to IDLE, set rr to the other requester, clear the carry latch.
- Lock stall: if req[i] drops while in LOCKi, hold LOCKi and the carry latch indefinitely. No timeout.
- Idle drive: when there is no transfer, add_a/add_b/add_cin hold the mux of the rr-selected requester. The value is don't-care, but there must be no X.
- Latency: exactly 1 cycle from transfer to rsp_valid. Throughput is one transfer per cycle. Back-to-back transfers produce back-to-back responses.
- rsp_valid is cleared in every cycle without a preceding transfer. rsp_sum/rsp_cout/rsp_hi hold their last values.
- Widths: no internal arithmetic; the carry latch is 1 bit. Sum overflow is reported only via cout.
- Reset mid-operation, including in LOCKi:
  - Abort to IDLE, rr=0, carry latch 0.
  - A transfer in the reset cycle is discarded; there is no rsp_valid in the following cycle.

Decomposition:
- Shared package holds:
  - arb state enum {IDLE, LOCK0, LOCK1};
  - NREQ=2;
  - the WIDTH default constant (36).
- One natural sub-module, arb2_rr: 2-way round-robin/fixed-priority grant generator with a lock input.
- The operand mux, carry latch and response register stay in the top module.

Test Plan:
- Single add: req0, a=36'o1, b=36'o2, cin=0 -> gnt0 same cycle; next cycle rsp_valid=2'b01, rsp_sum=36'o3, rsp_cout=0, rsp_hi=0.
- Contention: after reset, req=2'b11 held with single ops for 4 cycles -> grants 0,1,0,1; each rsp_valid arrives one cycle after its grant.
- Double-word carry chain:
  - Stimulus: req1 dbl=1, low beat a=36'o777777777777, b=36'o1; high beat a=0, b=0; req0 held throughout.
  - Low response: sum 0, cout 1, rsp_hi=0.
  - High response: add_cin=1, sum 36'o1, rsp_hi=1.
  - req0 is granted only in the cycle after the high beat.
- Lock stall: req1 drops for 3 cycles between its beats while req0 is high -> gnt stays 0 for those cycles; high beat still uses the latched carry when req1 returns.
- Reset in LOCK0 -> next cycle state IDLE, rsp_valid=0, carry latch 0; a following single add from req1 uses op_cin (cin=0 -> 36'o1+36'o1 = 36'o2).
- PRIO_FIXED=1, req=2'b11 for 3 cycles -> gnt=2'b01 every cycle.
